// File: rtl/tm_input_conditioner_if.sv
// Switch/button pins in, conditioned symbol stream out, for the Turing machine input front-end.
// master drives the raw pins and observes the results; slave is the conditioner itself.
interface tm_input_conditioner_if #(
  parameter int DATA_W   = 4,
  parameter int TAPE_LEN = 64
);
  localparam int CNT_W = $clog2(TAPE_LEN + 1);

  logic [DATA_W-1:0] data_raw;
  logic              next_raw;
  logic              done_raw;
  logic [DATA_W-1:0] data_out;
  logic              next_pulse;
  logic              done_pulse;
  logic [CNT_W-1:0]  sym_count;
  logic              tape_full;
  logic              loading;

  modport master (
    output data_raw, next_raw, done_raw,
    input  data_out, next_pulse, done_pulse, sym_count, tape_full, loading
  );

  modport slave (
    input  data_raw, next_raw, done_raw,
    output data_out, next_pulse, done_pulse, sym_count, tape_full, loading
  );
endinterface

// File: rtl/tm_input_conditioner.sv
// Synchronises and debounces the tape-loading switches/buttons and emits one-cycle Next/Done
// strobes with the symbol latched alongside, locking out input once loading ends or the tape fills.
module tm_input_conditioner #(
  parameter int DATA_W          = 4,
  parameter int TAPE_LEN        = 64,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  tm_input_conditioner_if.slave bus
);
  localparam int CNT_W  = $clog2(TAPE_LEN + 1);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int NEXT_B = 0;
  localparam int DONE_B = 1;

  typedef enum logic {ST_LOAD, ST_DONE} state_t;

  logic [DATA_W-1:0] data_meta_q, data_sync_q;
  logic [1:0]        btn_meta_q, btn_sync_q;
  logic [1:0]        btn_deb_q, btn_deb_d, btn_rise;
  logic [DB_W-1:0]   db_cnt_q [2];
  logic [DB_W-1:0]   db_cnt_d [2];

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              next_pulse_q, next_pulse_d;
  logic              done_pulse_q, done_pulse_d;
  logic [CNT_W-1:0]  sym_count_q, sym_count_d;

  // Per-button debounce: a level change is accepted only after DEBOUNCE_CYCLES differing cycles.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    btn_deb_d = btn_deb_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (btn_sync_q[i] != btn_deb_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) btn_deb_d[i] = ~btn_deb_q[i];
        else                                           db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
    // Rise is taken from the next debounced level so the strobe registers on the same edge.
    btn_rise = btn_deb_d & ~btn_deb_q;
  end

  always_comb begin
    state_d      = state_q;
    data_out_d   = data_out_q;
    sym_count_d  = sym_count_q;
    next_pulse_d = 1'b0;
    done_pulse_d = 1'b0;
    case (state_q)
      ST_LOAD: begin
        // Done outranks a coincident Next; a Next on a full tape is silently dropped.
        if (btn_rise[DONE_B]) begin
          done_pulse_d = 1'b1;
          state_d      = ST_DONE;
        end else if (btn_rise[NEXT_B] && (sym_count_q != CNT_W'(TAPE_LEN))) begin
          next_pulse_d = 1'b1;
          data_out_d   = data_sync_q;
          sym_count_d  = sym_count_q + CNT_W'(1);
        end
      end
      ST_DONE: ;
      default: state_d = ST_LOAD;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_meta_q  <= '0;
      data_sync_q  <= '0;
      btn_meta_q   <= '0;
      btn_sync_q   <= '0;
      btn_deb_q    <= '0;
      db_cnt_q[0]  <= '0;
      db_cnt_q[1]  <= '0;
      state_q      <= ST_LOAD;
      data_out_q   <= '0;
      next_pulse_q <= 1'b0;
      done_pulse_q <= 1'b0;
      sym_count_q  <= '0;
    end else begin
      data_meta_q  <= bus.data_raw;
      data_sync_q  <= data_meta_q;
      btn_meta_q   <= {bus.done_raw, bus.next_raw};
      btn_sync_q   <= btn_meta_q;
      btn_deb_q    <= btn_deb_d;
      db_cnt_q[0]  <= db_cnt_d[0];
      db_cnt_q[1]  <= db_cnt_d[1];
      state_q      <= state_d;
      data_out_q   <= data_out_d;
      next_pulse_q <= next_pulse_d;
      done_pulse_q <= done_pulse_d;
      sym_count_q  <= sym_count_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.next_pulse = next_pulse_q;
  assign bus.done_pulse = done_pulse_q;
  assign bus.sym_count  = sym_count_q;
  assign bus.tape_full  = (sym_count_q == CNT_W'(TAPE_LEN));
  assign bus.loading    = (state_q == ST_LOAD);
endmodule

// File: tb/tb_tm_input_conditioner.sv
// Randomised bench for tm_input_conditioner: stimulus pushes predicted strobes into a scoreboard,
// a negedge monitor pops and compares them whenever the DUT emits a pulse.
module tb_tm_input_conditioner;
  localparam int DATA_W   = 4;
  localparam int TAPE_LEN = 64;
  localparam int DEB      = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  tm_input_conditioner_if #(.DATA_W(DATA_W), .TAPE_LEN(TAPE_LEN)) bus ();

  tm_input_conditioner #(
    .DATA_W(DATA_W), .TAPE_LEN(TAPE_LEN), .DEBOUNCE_CYCLES(DEB)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit        is_done;
    logic [3:0] data;
    int        count;
    bit        loading;
    int        at_cyc;   // -1 when the press was bouncy and its exact edge is not predicted
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model state: what the loader should have accepted so far.
  int         m_count = 0;
  bit         m_done  = 1'b0;
  logic [3:0] m_data  = 4'h0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_press(bit nxt, bit dn, logic [3:0] d, int at);
    exp_t e;
    if (m_done) return;
    if (dn) begin
      m_done = 1'b1;
      e = '{is_done: 1'b1, data: m_data, count: m_count, loading: 1'b0, at_cyc: at};
      sb_q.push_back(e);
    end else if (nxt && m_count < TAPE_LEN) begin
      m_count++;
      m_data = d;
      e = '{is_done: 1'b0, data: d, count: m_count, loading: 1'b1, at_cyc: at};
      sb_q.push_back(e);
    end
  endfunction

  always @(negedge clock) begin
    if (!reset && (bus.next_pulse || bus.done_pulse)) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: next_pulse=%0b done_pulse=%0b, required no pulse (t=%0t)",
                 bus.next_pulse, bus.done_pulse, $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("next_pulse", 32'(bus.next_pulse), 32'(!mon_e.is_done));
        check("done_pulse", 32'(bus.done_pulse), 32'(mon_e.is_done));
        check("data_out",   32'(bus.data_out),   32'(mon_e.data));
        check("sym_count",  32'(bus.sym_count),  32'(mon_e.count));
        check("loading",    32'(bus.loading),    32'(mon_e.loading));
        check("tape_full",  32'(bus.tape_full),  32'(mon_e.count == TAPE_LEN));
        if (mon_e.at_cyc >= 0) check("pulse_latency", 32'(cyc), 32'(mon_e.at_cyc));
      end
    end
  end

  // One press/release of Next and/or Done, clean or with 2-cycle bounce on both edges.
  task automatic press(bit nxt, bit dn, logic [3:0] d, bit bouncy);
    int at;
    int hold;
    @(negedge clock);
    bus.data_raw = d;
    if (bouncy) begin
      for (int k = 0; k < 6; k++) begin
        bus.next_raw = nxt & (k % 2 == 0);
        bus.done_raw = dn  & (k % 2 == 0);
        repeat (2) @(negedge clock);
      end
      at   = -1;
      hold = 10;
    end else begin
      at   = cyc + 2 + DEB;
      hold = $urandom_range(7, 12);
    end
    bus.next_raw = nxt;
    bus.done_raw = dn;
    model_press(nxt, dn, d, at);
    repeat (hold) @(negedge clock);
    if (bouncy) begin
      for (int k = 0; k < 6; k++) begin
        bus.next_raw = nxt & (k % 2 == 1);
        bus.done_raw = dn  & (k % 2 == 1);
        repeat (2) @(negedge clock);
      end
    end
    bus.next_raw = 1'b0;
    bus.done_raw = 1'b0;
    repeat (bouncy ? 10 : 8) @(negedge clock);
  endtask

  task automatic wiggle_data();
    repeat (5) begin
      @(negedge clock);
      bus.data_raw = 4'($urandom);
    end
    repeat (3) @(negedge clock);
    check("data_out_unchanged", 32'(bus.data_out), 32'(m_data));
  endtask

  // Asynchronous mid-cycle reset; outputs must clear before the next clock edge.
  task automatic do_reset(bit keep_next);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("rst_data_out",   32'(bus.data_out),   32'h0);
    check("rst_next_pulse", 32'(bus.next_pulse), 32'h0);
    check("rst_done_pulse", 32'(bus.done_pulse), 32'h0);
    check("rst_sym_count",  32'(bus.sym_count),  32'h0);
    check("rst_tape_full",  32'(bus.tape_full),  32'h0);
    check("rst_loading",    32'(bus.loading),    32'h1);
    check("sb_drained_before_reset", 32'(sb_q.size()), 32'h0);
    sb_q.delete();
    m_count = 0;
    m_done  = 1'b0;
    m_data  = 4'h0;
    if (!keep_next) bus.next_raw = 1'b0;
    bus.done_raw = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] d;
    bus.data_raw = 4'h0;
    bus.next_raw = 1'b0;
    bus.done_raw = 1'b0;
    repeat (3) @(negedge clock);
    check("init_data_out",  32'(bus.data_out),  32'h0);
    check("init_sym_count", 32'(bus.sym_count), 32'h0);
    check("init_loading",   32'(bus.loading),   32'h1);
    check("init_tape_full", 32'(bus.tape_full), 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Clean press, then a bouncy press/release.
    press(1'b1, 1'b0, 4'hA, 1'b0);
    check("clean_count", 32'(bus.sym_count), 32'd1);
    check("clean_data",  32'(bus.data_out),  32'hA);
    press(1'b1, 1'b0, 4'($urandom), 1'b1);
    check("bounce_count", 32'(bus.sym_count), 32'd2);
    wiggle_data();

    // Fill the tape, then one press too many.
    do_reset(1'b0);
    for (int i = 0; i < TAPE_LEN; i++) press(1'b1, 1'b0, 4'(i % 16), (i % 8) == 3);
    check("full_count", 32'(bus.sym_count), 32'(TAPE_LEN));
    check("full_flag",  32'(bus.tape_full), 32'h1);
    press(1'b1, 1'b0, 4'h5, 1'b0);
    check("overflow_count", 32'(bus.sym_count), 32'(TAPE_LEN));
    check("overflow_data",  32'(bus.data_out),  32'hF);
    check("overflow_full",  32'(bus.tape_full), 32'h1);

    // Simultaneous Next+Done after three loads, then lock-out.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 4'($urandom), 1'b0);
    press(1'b1, 1'b1, 4'($urandom), 1'b0);
    check("sim_count",   32'(bus.sym_count), 32'd3);
    check("sim_loading", 32'(bus.loading),   32'h0);
    press(1'b1, 1'b0, 4'($urandom), 1'b0);
    press(1'b0, 1'b1, 4'($urandom), 1'b1);
    check("locked_count", 32'(bus.sym_count), 32'd3);
    check("locked_data",  32'(bus.data_out),  32'(m_data));

    // Reset two cycles before the pulse edge of a clean press.
    do_reset(1'b0);
    @(negedge clock);
    bus.data_raw = 4'h7;
    bus.next_raw = 1'b1;
    repeat (3) @(negedge clock);
    do_reset(1'b0);
    repeat (12) @(negedge clock);
    check("mid_deb_count", 32'(bus.sym_count), 32'h0);
    press(1'b1, 1'b0, 4'h3, 1'b0);
    check("fresh_count", 32'(bus.sym_count), 32'd1);

    // Next held through reset release gives exactly one rise afterwards.
    @(negedge clock);
    d = 4'($urandom);
    bus.data_raw = d;
    bus.next_raw = 1'b1;
    do_reset(1'b1);
    model_press(1'b1, 1'b0, d, -1);
    repeat (12) @(negedge clock);
    bus.next_raw = 1'b0;
    repeat (8) @(negedge clock);
    check("held_count", 32'(bus.sym_count), 32'd1);

    // Random mix of clean and bouncy presses with data noise between them.
    for (int i = 0; i < 12; i++) begin
      press(1'b1, 1'b0, 4'($urandom), $urandom_range(0, 3) == 0);
      wiggle_data();
    end
    check("rand_count", 32'(bus.sym_count), 32'(m_count));

    repeat (20) @(negedge clock);
    check("sb_empty_at_end", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
